demux1to4_tdm: RTL
==================

// Module: demux1to4_tdm
// PURPOSE
// - Receive side of the 4:1 channel mux: splits a time-division stream of 4 slots/frame back into channels A..D.
// - Slots are staged in shadow registers; a complete frame is published to the output registers.
// - Output frame is offered with a valid/ack handshake. Backpressure reaches the stream through in_ready.
// - Sits between the serial link and the per-channel consumers.
// PARAMETERS
// - WIDTH  8  bits per slot sample and per output channel
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous active-low reset
// - in_valid    in   1      in_data/in_sync present this cycle
// - in_data     in   WIDTH  slot sample
// - in_sync     in   1      qualified by in_valid; marks slot 0 (channel A) of a frame
// - in_ready    out  1      beat accepted when in_valid & in_ready
// - out_a       out  WIDTH  channel A (slot 0) of the published frame
// - out_b       out  WIDTH  channel B (slot 1) of the published frame
// - out_c       out  WIDTH  channel C (slot 2) of the published frame
// - out_d       out  WIDTH  channel D (slot 3) of the published frame
// - frame_valid out  1      out_a..out_d hold an unconsumed frame
// - frame_ack   in   1      consumer takes the frame; effective only while frame_valid=1
// - sync_err    out  1      one-cycle pulse on a sync/slot misalignment
// BEHAVIOUR
// - Reset (async, rst_n=0): state=HUNT, slot=0, shadows=0, out_a..d=0, frame_valid=0, sync_err=0, in_ready=1.
// - States:
//   - HUNT: accepted beats without in_sync are discarded. An accepted beat with in_sync writes shadow A, sets slot=1, enters RUN.
//   - RUN: each accepted beat writes shadow[slot] and then slot+1.
//     - Slot 3 accepted: publish the frame, slot=0, stay in RUN.
// - Publish (registered; visible the cycle after the slot-3 accept):
//   - out_a..c <= shadow A..C; out_d <= in_data; frame_valid <= 1.
// - Latency: slot-3 accept edge -> outputs and frame_valid valid 1 cycle later.
// - Handshake:
//   - frame_valid falls on the edge where frame_valid & frame_ack.
//   - in_ready = !(state==RUN & slot==3 & frame_valid & !frame_ack), combinational.
//   - A slot-3 beat therefore stalls until the consumer acks. Ack and publish may occur on the same edge: new frame is loaded and frame_valid stays 1.
//   - Outputs hold stable while frame_valid=1 and no publish occurs.
// - Misalignment (RUN):
//   - Accepted in_sync with slot!=0: sync_err pulses next cycle; the partial frame is dropped; the beat is taken as slot 0 (shadow A, slot=1).
//   - Accepted beat with slot==0 and no in_sync: sync_err pulse; beat discarded; state=HUNT.
// - in_sync with in_valid=0 is ignored. frame_ack with frame_valid=0 is ignored.
// - Shadow slots are not cleared between frames; only published values are observable.
// - rst_n mid-frame: the partial frame and the published frame are lost; all outputs return to reset values immediately.
// TESTING
// - T1 reset: rst_n=0 mid-stream -> out_a..d=0, frame_valid=0, in_ready=1, sync_err=0 with no clock edge required.
// - T2 nominal:
//   - Stimulus: beats 0x11(sync),0x22,0x33,0x44 back-to-back.
//   - Response: 1 cycle after 0x44 -> out_a..d=11,22,33,44 and frame_valid=1.
//   - Then frame_ack for 1 cycle -> frame_valid=0.
// - T3 backpressure:
//   - Stimulus: frame 1 unacked; frame 2 = 0xA1(sync),A2,A3,A4.
//   - Response: in_ready=0 while A4 is offered; outputs stay 11..44.
//   - Ack -> A4 accepted the same edge; next cycle outputs=A1..A4 and frame_valid=1.
// - T4 hunt: 0x55,0x66 without sync after reset -> discarded, no frame.
//   - Then a full synced frame -> published normally.
// - T5 resync: sync at slot 2 (0x10s,0x20,0x30s,0x40,0x50,0x60) -> sync_err pulse 1 cycle; published frame=30,40,50,60.
// - T6 lost sync: in RUN slot 0, beat 0x77 without sync -> sync_err pulse, state HUNT.
//   - Next frame without a leading sync -> no publish.

Source files
------------

// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: receive side of a 4-slot TDM link.
// Slots of one frame are staged in shadow registers. A complete frame is
// published to registered channel outputs out_a..out_d. The frame is offered
// with frame_valid/frame_ack, and an unacked frame stalls the next slot-3 beat
// through in_ready.
//
// Handshake rules:
// - Input side: a beat transfers on a rising edge where in_valid & in_ready.
//   in_ready is combinational and drops only when a slot-3 beat would
//   overwrite a published frame the consumer has not taken.
// - Output side: frame_valid holds until an edge with frame_valid & frame_ack.
//   An ack and a publish on the same edge load the new frame and keep
//   frame_valid high.
module demux1to4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             sync_err,
  output logic             dbg_state_o,
  output logic [1:0]       dbg_slot_o
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] shad_a_q;
  logic [WIDTH-1:0] shad_b_q;
  logic [WIDTH-1:0] shad_c_q;
  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  logic [WIDTH-1:0] out_c_q;
  logic [WIDTH-1:0] out_d_q;
  logic             frame_valid_q;
  logic             sync_err_q;
  logic             accept;

  // Stall only the beat that would publish over an unconsumed frame.
  assign in_ready = !((state_q == RUN) && (slot_q == 2'd3) && frame_valid_q && !frame_ack);
  assign accept   = in_valid && in_ready;

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_c       = out_c_q;
  assign out_d       = out_d_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign dbg_state_o = state_q;
  assign dbg_slot_o  = slot_q;

  // Frame alignment FSM, slot staging, publish and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shad_a_q      <= '0;
      shad_b_q      <= '0;
      shad_c_q      <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_c_q       <= '0;
      out_d_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;

      // Consumer takes the frame; a publish below on the same edge wins.
      if (frame_valid_q && frame_ack) begin
        frame_valid_q <= 1'b0;
      end

      if (accept) begin
        unique case (state_q)
          HUNT: begin
            // Discard everything until a sync beat marks slot 0.
            if (in_sync) begin
              shad_a_q <= in_data;
              slot_q   <= 2'd1;
              state_q  <= RUN;
            end
          end
          RUN: begin
            if (in_sync) begin
              // Sync anywhere but slot 0 drops the partial frame and restarts.
              if (slot_q != 2'd0) begin
                sync_err_q <= 1'b1;
              end
              shad_a_q <= in_data;
              slot_q   <= 2'd1;
            end else if (slot_q == 2'd0) begin
              // Expected a sync beat: alignment lost, go back to hunting.
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
            end else begin
              unique case (slot_q)
                2'd1: begin
                  shad_b_q <= in_data;
                  slot_q   <= 2'd2;
                end
                2'd2: begin
                  shad_c_q <= in_data;
                  slot_q   <= 2'd3;
                end
                2'd3: begin
                  // Slot D goes straight to the output with the staged slots.
                  out_a_q       <= shad_a_q;
                  out_b_q       <= shad_b_q;
                  out_c_q       <= shad_c_q;
                  out_d_q       <= in_data;
                  frame_valid_q <= 1'b1;
                  slot_q        <= 2'd0;
                end
                default: begin
                end
              endcase
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

endmodule
